// File: rtl/gctr_sequencer.sv
// gctr_sequencer: command-side controller for gctr_block.
// For one AES-GCM packet it issues the hash-key request, one counter-block
// request per input block, then the Y0 request. For an AES-only block it
// issues a single block request. Each result is captured on a rising edge of
// iResult_valid and handed downstream. A watchdog aborts the packet if
// gctr_block stays silent for too long.
module gctr_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iStart,
  input  logic         iOpMode,
  input  logic         iEncdec,
  input  logic         iKeylen,
  input  logic [255:0] iKey,
  input  logic [95:0]  iIV,
  input  logic [127:0] iIn_block,
  input  logic         iIn_last,
  input  logic         iIn_valid,
  output logic         oIn_ready,
  output logic         oInit,
  output logic         oOpMode,
  output logic         oEncdec,
  output logic         oKeylen,
  output logic [255:0] oKey,
  output logic         oKey_valid,
  output logic [95:0]  oIV,
  output logic         oIV_valid,
  output logic         oY0,
  output logic         oHkey_indicator,
  output logic [127:0] oBlock,
  output logic         oBlock_valid,
  input  logic [127:0] iResult,
  input  logic         iResult_valid,
  output logic [127:0] oH,
  output logic         oH_valid,
  output logic [127:0] oOut_block,
  output logic         oOut_last,
  output logic         oOut_valid,
  input  logic         iOut_ready,
  output logic [127:0] oEky0,
  output logic         oEky0_valid,
  output logic         oBusy,
  output logic         oDone,
  output logic         oError
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HKEY,
    S_BLK_WAIT_IN,
    S_BLK,
    S_OUT_HOLD,
    S_Y0,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  // Widened by one bit so the compare against count+1 cannot wrap.
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t state_q, state_d;

  // Latched packet configuration
  logic         op_mode_q, op_mode_d;
  logic         encdec_q, encdec_d;
  logic         keylen_q, keylen_d;
  logic [255:0] key_q, key_d;
  logic [95:0]  iv_q, iv_d;

  // Block in flight towards gctr_block and its last marker
  logic [127:0] block_q, block_d;
  logic         last_q, last_d;

  // Result side registers
  logic [127:0] out_block_q, out_block_d;
  logic         out_last_q, out_last_d;
  logic [127:0] h_q, h_d;
  logic         h_valid_q, h_valid_d;
  logic [127:0] eky0_q, eky0_d;
  logic         eky0_valid_q, eky0_valid_d;
  logic         error_q, error_d;

  // Sequencing helpers
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic         res_valid_prev_q, res_valid_prev_d;
  logic         gap_to_y0_q, gap_to_y0_d;

  logic in_req;
  logic res_edge;
  logic timeout_hit;
  logic start_acc;
  logic in_fire;
  logic out_fire;

  // Decode the per-cycle events that every other process keys off.
  always_comb begin
    in_req      = (state_q == S_HKEY) || (state_q == S_BLK) || (state_q == S_Y0);
    res_edge    = iResult_valid && !res_valid_prev_q;
    timeout_hit = in_req && !res_edge &&
                  (({1'b0, wait_cnt_q} + 17'd1) == TIMEOUT_LIMIT);
    start_acc   = (state_q == S_IDLE) && iStart;
    in_fire     = (state_q == S_BLK_WAIT_IN) && iIn_valid;
    out_fire    = (state_q == S_OUT_HOLD) && iOut_ready;
  end

  // State register; reset abandons any packet in progress.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a result edge always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = iOpMode ? S_BLK_WAIT_IN : S_HKEY;
        end
      end
      S_HKEY: begin
        if (res_edge) begin
          state_d = S_GAP;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_BLK_WAIT_IN: begin
        if (in_fire) begin
          state_d = S_BLK;
        end
      end
      S_BLK: begin
        if (res_edge) begin
          state_d = S_OUT_HOLD;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_OUT_HOLD: begin
        if (out_fire) begin
          state_d = op_mode_q ? S_DONE : S_GAP;
        end
      end
      S_Y0: begin
        if (res_edge) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        state_d = gap_to_y0_q ? S_Y0 : S_BLK_WAIT_IN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs decoded from the current state only.
  always_comb begin
    oInit           = 1'b0;
    oHkey_indicator = 1'b0;
    oBlock_valid    = 1'b0;
    oY0             = 1'b0;
    oKey_valid      = 1'b0;
    oIV_valid       = 1'b0;
    oIn_ready       = 1'b0;
    oOut_valid      = 1'b0;
    oDone           = 1'b0;
    oBusy           = (state_q != S_IDLE);
    case (state_q)
      S_HKEY: begin
        oInit           = 1'b1;
        oHkey_indicator = 1'b1;
        oKey_valid      = 1'b1;
        oIV_valid       = !op_mode_q;
      end
      S_BLK: begin
        oInit        = 1'b1;
        oBlock_valid = 1'b1;
        oKey_valid   = 1'b1;
        oIV_valid    = !op_mode_q;
      end
      S_Y0: begin
        oInit      = 1'b1;
        oY0        = 1'b1;
        oKey_valid = 1'b1;
        oIV_valid  = !op_mode_q;
      end
      S_BLK_WAIT_IN: begin
        oIn_ready  = 1'b1;
        oKey_valid = 1'b1;
        oIV_valid  = !op_mode_q;
      end
      S_OUT_HOLD: begin
        oOut_valid = 1'b1;
        oKey_valid = 1'b1;
        oIV_valid  = !op_mode_q;
      end
      S_GAP: begin
        oKey_valid = 1'b1;
        oIV_valid  = !op_mode_q;
      end
      S_DONE: begin
        oDone = 1'b1;
      end
      default: begin
        oBusy = (state_q != S_IDLE);
      end
    endcase
  end

  // Datapath next values: configuration latch, block capture, result capture,
  // watchdog counter and the sticky error flag.
  always_comb begin
    op_mode_d        = op_mode_q;
    encdec_d         = encdec_q;
    keylen_d         = keylen_q;
    key_d            = key_q;
    iv_d             = iv_q;
    block_d          = block_q;
    last_d           = last_q;
    out_block_d      = out_block_q;
    out_last_d       = out_last_q;
    h_d              = h_q;
    h_valid_d        = 1'b0;
    eky0_d           = eky0_q;
    eky0_valid_d     = 1'b0;
    error_d          = error_q;
    gap_to_y0_d      = gap_to_y0_q;
    res_valid_prev_d = iResult_valid;
    wait_cnt_d       = (in_req && !res_edge) ? (wait_cnt_q + 16'd1) : 16'd0;

    if (start_acc) begin
      op_mode_d = iOpMode;
      encdec_d  = iEncdec;
      keylen_d  = iKeylen;
      key_d     = iKey;
      iv_d      = iIV;
      error_d   = 1'b0;
    end

    if (in_fire) begin
      block_d = iIn_block;
      last_d  = iIn_last;
    end

    if (res_edge && (state_q == S_HKEY)) begin
      h_d         = iResult;
      h_valid_d   = 1'b1;
      gap_to_y0_d = 1'b0;
    end

    if (res_edge && (state_q == S_BLK)) begin
      out_block_d = iResult;
      out_last_d  = last_q;
    end

    if (res_edge && (state_q == S_Y0)) begin
      eky0_d       = iResult;
      eky0_valid_d = 1'b1;
    end

    if (out_fire) begin
      gap_to_y0_d = last_q;
    end

    if (timeout_hit) begin
      error_d = 1'b1;
    end
  end

  // Datapath registers; reset clears every visible value, including the key.
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      op_mode_q        <= 1'b0;
      encdec_q         <= 1'b0;
      keylen_q         <= 1'b0;
      key_q            <= '0;
      iv_q             <= '0;
      block_q          <= '0;
      last_q           <= 1'b0;
      out_block_q      <= '0;
      out_last_q       <= 1'b0;
      h_q              <= '0;
      h_valid_q        <= 1'b0;
      eky0_q           <= '0;
      eky0_valid_q     <= 1'b0;
      error_q          <= 1'b0;
      gap_to_y0_q      <= 1'b0;
      res_valid_prev_q <= 1'b0;
      wait_cnt_q       <= '0;
    end else begin
      op_mode_q        <= op_mode_d;
      encdec_q         <= encdec_d;
      keylen_q         <= keylen_d;
      key_q            <= key_d;
      iv_q             <= iv_d;
      block_q          <= block_d;
      last_q           <= last_d;
      out_block_q      <= out_block_d;
      out_last_q       <= out_last_d;
      h_q              <= h_d;
      h_valid_q        <= h_valid_d;
      eky0_q           <= eky0_d;
      eky0_valid_q     <= eky0_valid_d;
      error_q          <= error_d;
      gap_to_y0_q      <= gap_to_y0_d;
      res_valid_prev_q <= res_valid_prev_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign oOpMode     = op_mode_q;
  assign oEncdec     = encdec_q;
  assign oKeylen     = keylen_q;
  assign oKey        = key_q;
  assign oIV         = iv_q;
  assign oBlock      = block_q;
  assign oOut_block  = out_block_q;
  assign oOut_last   = out_last_q;
  assign oH          = h_q;
  assign oH_valid    = h_valid_q;
  assign oEky0       = eky0_q;
  assign oEky0_valid = eky0_valid_q;
  assign oError      = error_q;

endmodule

// File: tb/tb_gctr_sequencer.sv
// Bench for gctr_sequencer. A behavioural stand-in for gctr_block answers
// each request after a random latency with a simple keyed transform, and a
// queue of expected output blocks is filled as input blocks are accepted.
module tb_gctr_sequencer;

  localparam logic [255:0] KEY256 =
    256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
  localparam logic [95:0]  IV96   = 96'h12153524C0895E81B2C28465;
  localparam logic [255:0] KEY_AES =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] PT_AES = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY128 = 128'hAD7A2BD03EAC835A6F620FDCB506B345;
  localparam logic [127:0] H_SALT = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;

  logic         iClk = 1'b0;
  logic         iRstn, iStart, iOpMode, iEncdec, iKeylen;
  logic [255:0] iKey;
  logic [95:0]  iIV;
  logic [127:0] iIn_block;
  logic         iIn_last, iIn_valid, oIn_ready;
  logic         oInit, oOpMode, oEncdec, oKeylen;
  logic [255:0] oKey;
  logic         oKey_valid;
  logic [95:0]  oIV;
  logic         oIV_valid, oY0, oHkey_indicator;
  logic [127:0] oBlock;
  logic         oBlock_valid;
  logic [127:0] iResult;
  logic         iResult_valid;
  logic [127:0] oH;
  logic         oH_valid;
  logic [127:0] oOut_block;
  logic         oOut_last, oOut_valid, iOut_ready;
  logic [127:0] oEky0;
  logic         oEky0_valid, oBusy, oDone, oError;

  logic [880:0] all_outs;
  assign all_outs = {oIn_ready, oInit, oOpMode, oEncdec, oKeylen, oKey, oKey_valid,
                     oIV, oIV_valid, oY0, oHkey_indicator, oBlock, oBlock_valid,
                     oH, oH_valid, oOut_block, oOut_last, oOut_valid, oEky0,
                     oEky0_valid, oBusy, oDone, oError};

  int total = 0;
  int bad = 0;
  int h_count = 0;
  int eky0_count = 0;
  int done_count = 0;
  int req_count = 0;

  logic [127:0] exp_q[$];
  logic         exp_last_q[$];
  logic [127:0] exp_h, exp_eky0;
  logic [255:0] cur_key;
  logic [95:0]  cur_iv;
  logic         exp_iv_valid;
  logic [127:0] pt[3];

  logic         stub_mute = 1'b0;
  logic         stub_pending = 1'b0;
  logic         stub_init_prev = 1'b0;
  int           stub_countdown = 0;

  logic         mon_rv_prev = 1'b0;
  logic         mon_edge_seen = 1'b0;
  logic         mon_init_prev = 1'b0;
  logic [127:0] mon_exp;
  logic         mon_exp_last;

  always #5 iClk = ~iClk;

  gctr_sequencer #(.TIMEOUT_CYCLES(10)) dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iOpMode(iOpMode),
    .iEncdec(iEncdec), .iKeylen(iKeylen), .iKey(iKey), .iIV(iIV),
    .iIn_block(iIn_block), .iIn_last(iIn_last), .iIn_valid(iIn_valid),
    .oIn_ready(oIn_ready), .oInit(oInit), .oOpMode(oOpMode), .oEncdec(oEncdec),
    .oKeylen(oKeylen), .oKey(oKey), .oKey_valid(oKey_valid), .oIV(oIV),
    .oIV_valid(oIV_valid), .oY0(oY0), .oHkey_indicator(oHkey_indicator),
    .oBlock(oBlock), .oBlock_valid(oBlock_valid), .iResult(iResult),
    .iResult_valid(iResult_valid), .oH(oH), .oH_valid(oH_valid),
    .oOut_block(oOut_block), .oOut_last(oOut_last), .oOut_valid(oOut_valid),
    .iOut_ready(iOut_ready), .oEky0(oEky0), .oEky0_valid(oEky0_valid),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  // Stand-in gctr_block transforms
  function automatic logic [127:0] model_h(input logic [255:0] k);
    return k[255:128] ^ k[127:0] ^ H_SALT;
  endfunction

  function automatic logic [127:0] model_blk(input logic [255:0] k, input logic [95:0] v,
                                             input logic [127:0] b);
    return b ^ k[127:0] ^ {v, 32'h0000_0002};
  endfunction

  function automatic logic [127:0] model_y0(input logic [255:0] k, input logic [95:0] v);
    return k[127:0] ^ {v, 32'h0000_0001};
  endfunction

  // Stand-in gctr_block: one-cycle result pulse after a random latency
  initial begin
    iResult = '0;
    iResult_valid = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      iResult_valid = 1'b0;
      if (oInit && !stub_init_prev) req_count++;
      stub_init_prev = oInit;
      if (!oInit) begin
        stub_pending = 1'b0;
      end else if (!stub_pending) begin
        if (!stub_mute) begin
          stub_pending = 1'b1;
          stub_countdown = int'($urandom_range(5, 1));
        end
      end else if (stub_countdown > 0) begin
        stub_countdown--;
        if (stub_countdown == 0) begin
          if (oHkey_indicator) iResult = model_h(oKey);
          else if (oY0) iResult = model_y0(oKey, oIV);
          else iResult = model_blk(oKey, oIV, oBlock);
          iResult_valid = 1'b1;
        end
      end
    end
  end

  // Monitor: output scoreboard, result pulses and request protocol
  initial begin
    forever begin
      @(negedge iClk);
      if (mon_edge_seen) begin
        total++;
        if (oInit !== 1'b0) begin
          bad++;
          $display("[TB] FAIL init_drop: oInit=%b required 0 after result edge", oInit);
        end
      end
      mon_edge_seen = iResult_valid && !mon_rv_prev && oInit;
      mon_rv_prev = iResult_valid;
      if (oInit && !mon_init_prev) begin
        total++;
        if (oIV_valid !== exp_iv_valid) begin
          bad++;
          $display("[TB] FAIL iv_valid: got %b required %b", oIV_valid, exp_iv_valid);
        end
      end
      mon_init_prev = oInit;
      if (oOut_valid && iOut_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL out_unexpected: got %h with no block pending", oOut_block);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_exp_last = exp_last_q.pop_front();
          if (oOut_block !== mon_exp || oOut_last !== mon_exp_last) begin
            bad++;
            $display("[TB] FAIL out_block: got %h last=%b required %h last=%b",
                     oOut_block, oOut_last, mon_exp, mon_exp_last);
          end
        end
      end
      if (oH_valid) begin
        h_count++;
        total++;
        if (oH !== exp_h) begin
          bad++;
          $display("[TB] FAIL h_value: got %h required %h", oH, exp_h);
        end
      end
      if (oEky0_valid) begin
        eky0_count++;
        total++;
        if (oEky0 !== exp_eky0) begin
          bad++;
          $display("[TB] FAIL eky0_value: got %h required %h", oEky0, exp_eky0);
        end
      end
      if (oDone) done_count++;
    end
  end

  task automatic start_packet(input logic mode, input logic enc, input logic kl,
                              input logic [255:0] key, input logic [95:0] iv);
    iOpMode = mode;
    iEncdec = enc;
    iKeylen = kl;
    iKey = key;
    iIV = iv;
    cur_key = key;
    cur_iv = iv;
    exp_iv_valid = !mode;
    exp_h = model_h(key);
    exp_eky0 = model_y0(key, iv);
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b, input logic last);
    int n;
    n = 0;
    iIn_block = b;
    iIn_last = last;
    iIn_valid = 1'b1;
    @(negedge iClk);
    while (!oIn_ready && n < 100) begin
      @(negedge iClk);
      n++;
    end
    total++;
    if (oIn_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL in_ready_wait: oIn_ready=%b required 1 within 100 cycles", oIn_ready);
    end else begin
      exp_q.push_back(model_blk(cur_key, cur_iv, b));
      exp_last_q.push_back(last);
    end
    @(posedge iClk);
    #1;
    iIn_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    int d0;
    n = 0;
    d0 = done_count;
    while (done_count == d0 && n < 400) begin
      @(negedge iClk);
      n++;
    end
    total++;
    if (done_count != d0 + 1) begin
      bad++;
      $display("[TB] FAIL %s_done: done pulses=%0d required 1", name, done_count - d0);
    end
    repeat (3) @(posedge iClk);
    #1;
    total++;
    if (done_count != d0 + 1 || oBusy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_idle: done pulses=%0d busy=%b pending=%0d required 1/0/0",
               name, done_count - d0, oBusy, exp_q.size());
    end
  endtask

  task automatic test_reset;
    iRstn = 1'b0;
    iStart = 1'b0;
    iOpMode = 1'b0;
    iEncdec = 1'b0;
    iKeylen = 1'b0;
    iKey = '0;
    iIV = '0;
    iIn_block = '0;
    iIn_last = 1'b0;
    iIn_valid = 1'b0;
    iOut_ready = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h required all zero", all_outs);
    end
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
  endtask

  task automatic test_gcm(input logic enc);
    int h0;
    int e0;
    h0 = h_count;
    e0 = eky0_count;
    iOut_ready = 1'b1;
    start_packet(1'b0, enc, 1'b1, KEY256, IV96);
    @(negedge iClk);
    total++;
    if ({oBusy, oOpMode, oEncdec, oKeylen} !== {1'b1, 1'b0, enc, 1'b1} ||
        oKey !== KEY256 || oIV !== IV96) begin
      bad++;
      $display("[TB] FAIL gcm_config: busy/mode/enc/kl=%b%b%b%b required 10%b1",
               oBusy, oOpMode, oEncdec, oKeylen, enc);
    end
    @(posedge iClk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send_block(enc ? pt[i] : model_blk(KEY256, IV96, pt[i]), i == 2);
    end
    wait_done(enc ? "gcm_enc" : "gcm_dec");
    total++;
    if (h_count != h0 + 1 || eky0_count != e0 + 1 || oH !== exp_h || oEky0 !== exp_eky0) begin
      bad++;
      $display("[TB] FAIL gcm_pulses: h=%0d eky0=%0d required 1/1, oH=%h required %h",
               h_count - h0, eky0_count - e0, oH, exp_h);
    end
  endtask

  task automatic test_aes_only;
    int h0;
    int e0;
    h0 = h_count;
    e0 = eky0_count;
    iOut_ready = 1'b1;
    start_packet(1'b1, 1'b1, 1'b1, KEY_AES, 96'h0);
    send_block(PT_AES, 1'b1);
    wait_done("aes_enc");
    start_packet(1'b1, 1'b0, 1'b1, KEY_AES, 96'h0);
    send_block(model_blk(KEY_AES, 96'h0, PT_AES), 1'b1);
    wait_done("aes_dec");
    total++;
    if (h_count != h0 || eky0_count != e0) begin
      bad++;
      $display("[TB] FAIL aes_no_pulses: h=%0d eky0=%0d required 0/0", h_count - h0, eky0_count - e0);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int r0;
    logic [127:0] held;
    iOut_ready = 1'b1;
    start_packet(1'b0, 1'b1, 1'b1, KEY256, IV96);
    send_block(pt[0], 1'b0);
    send_block(pt[1], 1'b0);
    iOut_ready = 1'b0;
    held = model_blk(KEY256, IV96, pt[1]);
    n = 0;
    @(negedge iClk);
    while (!oOut_valid && n < 50) begin
      @(negedge iClk);
      n++;
    end
    r0 = req_count;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (oOut_valid !== 1'b1 || oOut_block !== held || oIn_ready !== 1'b0 || req_count != r0) begin
        bad++;
        $display("[TB] FAIL stall_%0d: valid=%b data=%h in_ready=%b reqs=%0d required 1/%h/0/0",
                 i, oOut_valid, oOut_block, oIn_ready, req_count - r0, held);
      end
      @(negedge iClk);
    end
    @(posedge iClk);
    #1;
    iOut_ready = 1'b1;
    send_block(pt[2], 1'b1);
    wait_done("backpressure");
  endtask

  task automatic test_protocol;
    int n;
    iOut_ready = 1'b1;
    start_packet(1'b0, 1'b1, 1'b1, KEY256, IV96);
    n = 0;
    @(negedge iClk);
    while (!oH_valid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    total++;
    if (oH_valid !== 1'b1 || oInit !== 1'b0 || oIn_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hkey_gap: h_valid=%b init=%b in_ready=%b required 1/0/0",
               oH_valid, oInit, oIn_ready);
    end
    @(negedge iClk);
    total++;
    if (oIn_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gap_len: oIn_ready=%b required 1 one cycle after gap", oIn_ready);
    end
    @(posedge iClk);
    #1;
    iOpMode = 1'b1;
    iEncdec = 1'b0;
    iKey = ~KEY256;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    @(negedge iClk);
    total++;
    if (oOpMode !== 1'b0 || oEncdec !== 1'b1 || oKey !== KEY256) begin
      bad++;
      $display("[TB] FAIL mid_start: mode=%b enc=%b required 0/1, key changed=%b",
               oOpMode, oEncdec, oKey !== KEY256);
    end
    @(posedge iClk);
    #1;
    send_block(pt[0], 1'b0);
    send_block(pt[1], 1'b0);
    send_block(pt[2], 1'b1);
    n = 0;
    @(negedge iClk);
    while (!oOut_valid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    @(negedge iClk);
    total++;
    if (oInit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL y0_gap: oInit=%b required 0 in gap", oInit);
    end
    @(negedge iClk);
    total++;
    if (oInit !== 1'b1 || oY0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL y0_request: init=%b y0=%b required 1/1", oInit, oY0);
    end
    @(posedge iClk);
    #1;
    wait_done("protocol");
  endtask

  task automatic test_timeout;
    int n;
    int d0;
    d0 = done_count;
    stub_mute = 1'b1;
    iOut_ready = 1'b1;
    start_packet(1'b0, 1'b1, 1'b1, KEY256, IV96);
    @(negedge iClk);
    total++;
    if (oInit !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_request: oInit=%b required 1", oInit);
    end
    n = 0;
    while (oError !== 1'b1 && n < 40) begin
      @(negedge iClk);
      n++;
    end
    total++;
    if (n != 10 || oInit !== 1'b0 || oBusy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_latency: error after %0d cycles init=%b busy=%b required 10/0/1",
               n, oInit, oBusy);
    end
    @(negedge iClk);
    total++;
    if (oBusy !== 1'b0 || oError !== 1'b1 || done_count != d0) begin
      bad++;
      $display("[TB] FAIL to_idle: busy=%b error=%b done=%0d required 0/1/0",
               oBusy, oError, done_count - d0);
    end
    stub_mute = 1'b0;
    @(posedge iClk);
    #1;
    start_packet(1'b1, 1'b1, 1'b1, KEY_AES, 96'h0);
    @(negedge iClk);
    total++;
    if (oError !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_clear: oError=%b required 0 after new start", oError);
    end
    @(posedge iClk);
    #1;
    send_block(PT_AES, 1'b1);
    wait_done("after_timeout");
  endtask

  task automatic test_reset_mid;
    int n;
    int d0;
    d0 = done_count;
    iOut_ready = 1'b1;
    start_packet(1'b0, 1'b1, 1'b1, KEY256, IV96);
    send_block(pt[0], 1'b0);
    n = 0;
    @(negedge iClk);
    while (!oBlock_valid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    iRstn = 1'b0;
    @(negedge iClk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs: got %h required all zero", all_outs);
    end
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    repeat (5) @(posedge iClk);
    #1;
    total++;
    if (done_count != d0 || oBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_nodone: done=%0d busy=%b required 0/0", done_count - d0, oBusy);
    end
    start_packet(1'b0, 1'b1, 1'b0, {128'h0, KEY128}, IV96);
    @(negedge iClk);
    total++;
    if (oKeylen !== 1'b0 || oKey !== {128'h0, KEY128}) begin
      bad++;
      $display("[TB] FAIL key128_config: keylen=%b key=%h required 0/%h", oKeylen, oKey, KEY128);
    end
    @(posedge iClk);
    #1;
    send_block(pt[0], 1'b1);
    wait_done("key128");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: bench did not complete");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    pt[0] = 128'h08000F101112131415161718191A1B1C;
    pt[1] = 128'h1D1E1F202122232425262728292A2B2C;
    pt[2] = 128'h2D2E2F303132333435363738393A0002;
    exp_h = '0;
    exp_eky0 = '0;
    cur_key = '0;
    cur_iv = '0;
    exp_iv_valid = 1'b0;
    test_reset;
    test_gcm(1'b1);
    test_gcm(1'b0);
    test_aes_only;
    test_backpressure;
    test_protocol;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
